// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial nibble receiver.
// The optional parity stage is selected by SERIAL_NIBBLE_RECEIVER_PARITY_EN.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } rx_state_t;

    localparam int         DEF_WIDTH   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b0011;

    // Bit counter width, wide enough to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Frame bit counter for the serial receiver. o_term flags that the next
// increment brings the count to WIDTH, i.e. the bit now on the line is the last.
module serial_bit_counter
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_load_one,
    input  logic i_inc,
    output logic o_term
);

    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_load_one) begin
            r_count <= CW'(1);
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_term = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_nibble_receiver.sv
// Serial-to-parallel receiver with one-entry valid/ready output buffer.
// Define SERIAL_NIBBLE_RECEIVER_PARITY_EN to add an even-parity bit after each frame.
module serial_nibble_receiver
    import serial_rx_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN)
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             serialIn,
    input  logic             frameStart,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic             match,
    output logic             overrun,
    output logic             parityError
);

    // Without parity the last bit goes straight from serialIn into the buffer,
    // so the accumulator only needs to hold the leading WIDTH-1 bits.
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    localparam int ACC_W = WIDTH;
`else
    localparam int ACC_W = WIDTH - 1;
`endif

    rx_state_t        r_state;
    rx_state_t        w_state_nx;
    logic [ACC_W-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_match;
    logic             r_overrun;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_out_word;
    logic             w_load_one;
    logic             w_inc;
    logic             w_term;
    logic             w_done;
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    logic             w_perr_set;
    logic             r_parity_err;
`endif

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .i_clk      (clockpulse),
        .i_clear    (clear),
        .i_load_one (w_load_one),
        .i_inc      (w_inc),
        .o_term     (w_term)
    );

    assign w_word = {r_acc[WIDTH-2:0], serialIn};

`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    assign w_out_word = r_acc[WIDTH-1:0];
`else
    assign w_out_word = w_word;
`endif

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load_one = 1'b0;
        w_inc      = 1'b0;
        w_done     = 1'b0;
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
        w_perr_set = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (frameStart) begin
                    w_load_one = 1'b1;
                    w_state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (frameStart) begin
                    w_load_one = 1'b1;
                end else begin
                    w_inc = 1'b1;
                    if (w_term) begin
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
                        w_state_nx = ST_PARITY;
`else
                        w_state_nx = ST_IDLE;
                        w_done     = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
            ST_PARITY: begin
                if (frameStart) begin
                    w_load_one = 1'b1;
                    w_state_nx = ST_SHIFT;
                end else begin
                    w_state_nx = ST_IDLE;
                    if (^{r_acc, serialIn}) begin
                        w_perr_set = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            r_acc <= '0;
        end else if (w_load_one) begin
            r_acc <= ACC_W'(serialIn);
        end else if (w_inc) begin
            r_acc <= w_word[ACC_W-1:0];
        end
    end

    // A completed word loads if the slot is free or is being drained this edge.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (w_done && (!r_valid || outReady)) begin
                r_data  <= w_out_word;
                r_valid <= 1'b1;
                r_match <= (w_out_word == PATTERN);
            end else begin
                if (w_done) begin
                    r_overrun <= 1'b1;
                end else if (r_valid && outReady) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            r_parity_err <= 1'b0;
        end else if (w_perr_set) begin
            r_parity_err <= 1'b1;
        end
    end
    assign parityError = r_parity_err;
`else
    assign parityError = 1'b0;
`endif

    assign outData  = r_data;
    assign outValid = r_valid;
    assign match    = r_match;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed plus randomized bench for serial_nibble_receiver against a frame-level model.
// Honors SERIAL_NIBBLE_RECEIVER_PARITY_EN when defined.
module tb_serial_nibble_receiver;

    localparam int         W = 4;
    localparam logic [W-1:0] P = 4'b0011;
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clockpulse = 1'b0;
    logic         clear      = 1'b1;
    logic         serialIn   = 1'b0;
    logic         frameStart = 1'b0;
    logic         outReady   = 1'b0;
    logic [W-1:0] outData;
    logic         outValid;
    logic         match;
    logic         overrun;
    logic         parityError;

    serial_nibble_receiver #(
        .WIDTH   (W),
        .PATTERN (P)
    ) dut (
        .clockpulse  (clockpulse),
        .clear       (clear),
        .serialIn    (serialIn),
        .frameStart  (frameStart),
        .outReady    (outReady),
        .outData     (outData),
        .outValid    (outValid),
        .match       (match),
        .overrun     (overrun),
        .parityError (parityError)
    );

    always #5 clockpulse = ~clockpulse;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: bits collected so far, word value, buffer contents.
    int           m_pos;
    int           m_word;
    bit           m_parph;
    logic [W-1:0] m_data;
    logic         m_valid, m_match, m_ovr, m_perr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic c, input logic f, input logic s, input logic r);
        bit done;
        done = 1'b0;
        if (c) begin
            m_pos = 0; m_word = 0; m_parph = 0;
            m_data = '0; m_valid = 0; m_match = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (f) begin
            m_pos = 1; m_word = int'(s); m_parph = 0;
        end else if (m_parph) begin
            m_parph = 0; m_pos = 0;
            if ((($countones(m_word) + int'(s)) % 2) != 0) m_perr = 1;
            else done = 1'b1;
        end else if (m_pos > 0) begin
            m_word = m_word * 2 + int'(s);
            m_pos++;
            if (m_pos == W) begin
                m_pos = 0;
                if (PAR) m_parph = 1;
                else done = 1'b1;
            end
        end
        m_match = 0;
        if (done && (!m_valid || r)) begin
            m_data  = W'(m_word);
            m_valid = 1;
            m_match = (W'(m_word) == P);
        end else if (done) begin
            m_ovr = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("outData", 16'(outData), 16'(m_data));
        chk("outValid", 16'(outValid), 16'(m_valid));
        chk("match", 16'(match), 16'(m_match));
        chk("overrun", 16'(overrun), 16'(m_ovr));
        chk("parityError", 16'(parityError), 16'(m_perr));
    endtask

    task automatic step(input logic c, input logic f, input logic s, input logic r);
        clear = c; frameStart = f; serialIn = s; outReady = r;
        @(posedge clockpulse);
        model_update(c, f, s, r);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic [W-1:0] rmask);
        for (int i = 0; i < W; i++) begin
            step(1'b0, (i == 0), w[W-1-i], rmask[W-1-i]);
        end
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_data", 16'(outData), 16'h0);
        chk("rst_valid", 16'(outValid), 16'h0);
        chk("rst_flags", 16'({match, overrun, parityError}), 16'h0);

`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
        send_frame(4'b0011, 4'b1111);
        step(0, 0, 0, 1);
        chk("par_ok_data", 16'(outData), 16'h3);
        chk("par_ok_valid", 16'(outValid), 16'h1);
        chk("par_ok_match", 16'(match), 16'h1);
        step(0, 0, 0, 1);
        send_frame(4'b0011, 4'b1111);
        step(0, 0, 1, 1);
        chk("par_bad_err", 16'(parityError), 16'h1);
        chk("par_bad_valid", 16'(outValid), 16'h0);
        step(1, 0, 0, 0);
`else
        send_frame(4'b0011, 4'b1111);
        chk("t1_data", 16'(outData), 16'h3);
        chk("t1_valid", 16'(outValid), 16'h1);
        chk("t1_match", 16'(match), 16'h1);
        step(0, 0, 0, 1);
        chk("t1_valid_drop", 16'(outValid), 16'h0);
        chk("t1_match_pulse", 16'(match), 16'h0);

        send_frame(4'b1010, 4'b0000);
        chk("t2_data", 16'(outData), 16'hA);
        chk("t2_match", 16'(match), 16'h0);
        send_frame(4'b0110, 4'b0000);
        chk("t2_overrun", 16'(overrun), 16'h1);
        chk("t2_data_kept", 16'(outData), 16'hA);
        chk("t2_valid_held", 16'(outValid), 16'h1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);

        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        send_frame(4'b1111, 4'b1111);
        chk("t3_data", 16'(outData), 16'hF);
        chk("t3_no_overrun", 16'(overrun), 16'h0);
        step(0, 0, 0, 1);

        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(1, 0, 0, 1);
        chk("t4_clr_valid", 16'(outValid), 16'h0);
        chk("t4_clr_data", 16'(outData), 16'h0);
        send_frame(4'b0110, 4'b1111);
        chk("t4_next_data", 16'(outData), 16'h6);
        step(0, 0, 0, 1);

        send_frame(4'b0101, 4'b0000);
        send_frame(4'b1001, 4'b0001);
        chk("t5_valid_cont", 16'(outValid), 16'h1);
        chk("t5_second_data", 16'(outData), 16'h9);
        step(0, 0, 0, 1);
`endif

        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 113) == 0, ($urandom % 5) == 0,
                 1'($urandom), ($urandom % 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
